// File: rtl/player_cmd_pkg.sv
// player_cmd_pkg -- shared opcodes, direction codes, arbiter state type and
// a saturating 8-bit add used by the player command arbiter.
package player_cmd_pkg;

   // Instruction opcodes (instr[15:12])
   localparam logic [3:0] HPY = 4'h1;
   localparam logic [3:0] DPY = 4'h2;
   localparam logic [3:0] MOV = 4'h5;

   // Movement direction codes (operand of a MOV instruction)
   localparam logic [7:0] UP    = 8'h00;
   localparam logic [7:0] LEFT  = 8'h01;
   localparam logic [7:0] DOWN  = 8'h02;
   localparam logic [7:0] RIGHT = 8'h03;

   typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} arb_state_e;

   function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
      logic [8:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[8] ? 8'hFF : s[7:0];
   endfunction

endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo -- damage-amount store for the player command arbiter.
//   PLAYER_CMD_QUEUE_EN defined   : DEPTH-entry FIFO (DEPTH power of two).
//   PLAYER_CMD_QUEUE_EN undefined : single-entry holding register, full = occupied.
// A push is accepted when not full, or when full and a pop happens in the
// same cycle (the freed slot is reused, occupancy unchanged).
// Ports: clk, reset (sync, active high), push/push_data, pop,
//        data (head entry), full, empty.
module cmd_fifo #(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       push,
   input  logic [7:0] push_data,
   input  logic       pop,
   output logic [7:0] data,
   output logic       full,
   output logic       empty
);

`ifdef PLAYER_CMD_QUEUE_EN
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wp, rp;
   logic [AW:0]   cnt;
   logic          do_push, do_pop;

   assign full    = (cnt == (AW+1)'(DEPTH));
   assign empty   = (cnt == '0);
   assign data    = mem[rp];
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk) begin
      if (reset) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else begin
         if (do_push) wp <= wp + AW'(1);
         if (do_pop)  rp <= rp + AW'(1);
         if (do_push && !do_pop)      cnt <= cnt + (AW+1)'(1);
         else if (!do_push && do_pop) cnt <= cnt - (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wp] <= push_data;
   end
`else
   logic [7:0] hold;
   logic       occ;

   assign full  = occ;
   assign empty = !occ;
   assign data  = hold;

   always_ff @(posedge clk) begin
      if (reset) begin
         occ  <= 1'b0;
         hold <= '0;
      end else if (push && (!occ || pop)) begin
         occ  <= 1'b1;
         hold <= push_data;
      end else if (pop) begin
         occ  <= 1'b0;
      end
   end
`endif

endmodule

// File: rtl/player_cmd_arbiter.sv
// player_cmd_arbiter -- merges heal, damage and movement requests into a
// single valid/ready instruction stream {op[3:0], operand[7:0], 4'h0}.
// Priority at grant: heal > damage queue head > movement.
// Macro PLAYER_CMD_QUEUE_EN selects a QDEPTH-entry damage FIFO; without it
// the damage store is a single holding register.
// Ports: clk, reset (sync, active high); mov_req/mov_dir (level),
//        dmg_req/dmg_amt and heal_req/heal_amt (pulses); instr/instr_valid/
//        instr_ready handshake; q_full; drop_cnt (saturating).
module player_cmd_arbiter
   import player_cmd_pkg::*;
#(
   parameter int QDEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mov_req,
   input  logic [7:0]  mov_dir,
   input  logic        dmg_req,
   input  logic [7:0]  dmg_amt,
   input  logic        heal_req,
   input  logic [7:0]  heal_amt,
   output logic [15:0] instr,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic        q_full,
   output logic [7:0]  drop_cnt
);

   arb_state_e  state, state_nxt;
   logic [15:0] instr_q, grant_instr;
   logic        grant, grant_heal;
   logic        hs, q_pop, q_push, q_empty, dmg_ok;
   logic [7:0]  q_head;

   // Heal amount accumulated since the last heal grant. A heal arriving in
   // the grant cycle is folded straight into the granted instruction.
   logic        heal_vld;
   logic [7:0]  heal_acc, heal_sum;
   logic        heal_have;

   assign instr       = instr_q;
   assign instr_valid = (state == ISSUE);
   assign hs          = instr_valid && instr_ready;
   assign heal_have   = heal_vld || heal_req;
   assign heal_sum    = heal_req ? sat_add8(heal_acc, heal_amt) : heal_acc;

   // Head is only released once its instruction is accepted.
   assign q_pop  = hs && (instr_q[15:12] == DPY);
   assign dmg_ok = dmg_req && (dmg_amt != 8'h00);
   assign q_push = dmg_ok;

   cmd_fifo #(.DEPTH(QDEPTH)) u_dmg_q (
      .clk       (clk),
      .reset     (reset),
      .push      (q_push),
      .push_data (dmg_amt),
      .pop       (q_pop),
      .data      (q_head),
      .full      (q_full),
      .empty     (q_empty)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      grant       = 1'b0;
      grant_heal  = 1'b0;
      grant_instr = instr_q;
      case (state)
         IDLE: begin
            if (heal_have) begin
               grant       = 1'b1;
               grant_heal  = 1'b1;
               grant_instr = {HPY, heal_sum, 4'h0};
            end else if (!q_empty) begin
               grant       = 1'b1;
               grant_instr = {DPY, q_head, 4'h0};
            end else if (mov_req) begin
               grant       = 1'b1;
               grant_instr = {MOV, mov_dir, 4'h0};
            end
            if (grant) state_nxt = ISSUE;
         end
         ISSUE: if (hs) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         instr_q  <= '0;
         heal_vld <= 1'b0;
         heal_acc <= '0;
         drop_cnt <= '0;
      end else begin
         if (grant) instr_q <= grant_instr;
         if (grant_heal) begin
            heal_vld <= 1'b0;
            heal_acc <= '0;
         end else begin
            heal_vld <= heal_have;
            heal_acc <= heal_sum;
         end
         // A same-cycle pop frees a slot, so only a full queue without pop drops.
         if (dmg_ok && q_full && !q_pop && drop_cnt != 8'hFF)
            drop_cnt <= drop_cnt + 8'd1;
      end
   end

endmodule

// File: tb/tb_player_cmd_arbiter.sv
module tb_player_cmd_arbiter;
   import player_cmd_pkg::*;

`ifdef PLAYER_CMD_QUEUE_EN
   localparam int D = 4;
`else
   localparam int D = 1;
`endif

   logic        clk = 1'b0;
   logic        reset, mov_req, dmg_req, heal_req, instr_ready;
   logic [7:0]  mov_dir, dmg_amt, heal_amt, drop_cnt;
   logic [15:0] instr;
   logic        instr_valid, q_full;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   player_cmd_arbiter #(.QDEPTH(4)) dut (
      .clk(clk), .reset(reset), .mov_req(mov_req), .mov_dir(mov_dir),
      .dmg_req(dmg_req), .dmg_amt(dmg_amt), .heal_req(heal_req),
      .heal_amt(heal_amt), .instr(instr), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .q_full(q_full), .drop_cnt(drop_cnt)
   );

   typedef struct {
      logic rst; logic mov; logic [7:0] dir; logic dmg; logic [7:0] damt;
      logic heal; logic [7:0] hamt; logic rdy;
      logic ev; logic [15:0] ei; logic eq; logic [7:0] ed;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(logic rst, logic mov, logic [7:0] dir, logic dmg,
                               logic [7:0] damt, logic heal, logic [7:0] hamt,
                               logic rdy, logic ev, logic [15:0] ei, logic eq,
                               logic [7:0] ed);
      vec_t v;
      v.rst = rst; v.mov = mov; v.dir = dir; v.dmg = dmg; v.damt = damt;
      v.heal = heal; v.hamt = hamt; v.rdy = rdy;
      v.ev = ev; v.ei = ei; v.eq = eq; v.ed = ed;
      return v;
   endfunction

   task automatic chk(input string nm, input int idx, input logic [15:0] act,
                      input logic [15:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      reset = v.rst; mov_req = v.mov; mov_dir = v.dir; dmg_req = v.dmg;
      dmg_amt = v.damt; heal_req = v.heal; heal_amt = v.hamt; instr_ready = v.rdy;
   endtask

   task automatic run_tbl(input string nm);
      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i]);
         @(posedge clk); #1;
         chk({nm, ".valid"}, i, 16'(instr_valid), 16'(tbl[i].ev));
         chk({nm, ".instr"}, i, instr, tbl[i].ei);
         chk({nm, ".q_full"}, i, 16'(q_full), 16'(tbl[i].eq));
         chk({nm, ".drop"}, i, 16'(drop_cnt), 16'(tbl[i].ed));
      end
      tbl.delete();
   endtask

   // Reference model: one in-flight instruction, damage amounts in a queue.
   bit          m_valid, m_hv;
   logic [15:0] m_instr;
   int          m_ha, m_drop;
   int          mq[$];

   task automatic model_step(input vec_t v);
      bit hs, pop, gh;
      int hsum;
      if (v.rst) begin
         m_valid = 0; m_instr = '0; m_hv = 0; m_ha = 0; m_drop = 0; mq.delete();
         return;
      end
      hs   = m_valid && v.rdy;
      pop  = hs && (m_instr[15:12] == 4'h2);
      hsum = v.heal ? ((m_ha + int'(v.hamt) > 255) ? 255 : m_ha + int'(v.hamt)) : m_ha;
      gh   = 0;
      if (!m_valid) begin
         if (m_hv || v.heal) begin
            m_instr = {4'h1, 8'(hsum), 4'h0}; m_valid = 1; gh = 1;
         end else if (mq.size() > 0) begin
            m_instr = {4'h2, 8'(mq[0]), 4'h0}; m_valid = 1;
         end else if (v.mov) begin
            m_instr = {4'h5, v.dir, 4'h0}; m_valid = 1;
         end
      end else if (hs) m_valid = 0;
      if (gh) begin m_hv = 0; m_ha = 0; end
      else begin m_hv = m_hv || v.heal; m_ha = hsum; end
      if (pop) void'(mq.pop_front());
      if (v.dmg && v.damt != 0) begin
         if (mq.size() < D) mq.push_back(int'(v.damt));
         else if (m_drop < 255) m_drop++;
      end
   endtask

   initial begin
      vec_t v;
      logic qa;
      int got[$];
      int n_exp;

      qa = (D == 1);
      // Priority heal > damage > move, then ordering of the three grants.
      tbl.push_back(mk(1,0,0,0,0,0,0,1, 0,16'h0000,0,0));
      tbl.push_back(mk(0,1,RIGHT,1,5,1,10,1, 1,16'h10A0,qa,0));
      tbl.push_back(mk(0,1,RIGHT,0,0,0,0,1, 0,16'h10A0,qa,0));
      tbl.push_back(mk(0,1,RIGHT,0,0,0,0,1, 1,16'h2050,qa,0));
      tbl.push_back(mk(0,1,RIGHT,0,0,0,0,1, 0,16'h2050,0,0));
      tbl.push_back(mk(0,1,RIGHT,0,0,0,0,1, 1,16'h5030,0,0));
      tbl.push_back(mk(0,0,0,0,0,0,0,1, 0,16'h5030,0,0));
      tbl.push_back(mk(0,0,0,0,0,0,0,1, 0,16'h5030,0,0));
      run_tbl("prio");

      // Heal accumulation with saturation; heal at handshake stays pending alone.
      tbl.push_back(mk(1,0,0,0,0,0,0,0, 0,16'h0000,0,0));
      tbl.push_back(mk(0,1,DOWN,0,0,0,0,0, 1,16'h5020,0,0));
      tbl.push_back(mk(0,0,0,0,0,1,200,0, 1,16'h5020,0,0));
      tbl.push_back(mk(0,0,0,0,0,1,100,0, 1,16'h5020,0,0));
      tbl.push_back(mk(0,0,0,0,0,0,0,1, 0,16'h5020,0,0));
      tbl.push_back(mk(0,0,0,0,0,0,0,1, 1,16'h1FF0,0,0));
      tbl.push_back(mk(0,0,0,0,0,1,7,1, 0,16'h1FF0,0,0));
      tbl.push_back(mk(0,0,0,0,0,0,0,1, 1,16'h1070,0,0));
      tbl.push_back(mk(0,0,0,0,0,0,0,1, 0,16'h1070,0,0));
      tbl.push_back(mk(0,0,0,0,0,0,0,1, 0,16'h1070,0,0));
      run_tbl("heal");

      // Stall holds instr; reset overrides handshake and discards requests.
      tbl.push_back(mk(1,0,0,0,0,0,0,0, 0,16'h0000,0,0));
      tbl.push_back(mk(0,1,LEFT,0,0,0,0,0, 1,16'h5010,0,0));
      tbl.push_back(mk(0,1,LEFT,0,0,0,0,0, 1,16'h5010,0,0));
      tbl.push_back(mk(0,1,LEFT,0,0,0,0,0, 1,16'h5010,0,0));
      tbl.push_back(mk(1,1,LEFT,1,9,1,50,1, 0,16'h0000,0,0));
      tbl.push_back(mk(0,0,0,0,0,0,0,1, 0,16'h0000,0,0));
      tbl.push_back(mk(0,0,0,0,0,0,0,1, 0,16'h0000,0,0));
      run_tbl("stall");

      // Five damage events against a stalled consumer.
      tbl.push_back(mk(1,0,0,0,0,0,0,0, 0,16'h0000,0,0));
      for (int k = 1; k <= 5; k++)
         tbl.push_back(mk(0,0,0,1,8'(k),0,0,0, (k >= 2), (k >= 2) ? 16'h2010 : 16'h0000,
                          (k >= D), (k > D) ? 8'(k - D) : 8'd0));
      run_tbl("fill");
      v = mk(0,0,0,0,0,0,0,1, 0,0,0,0);
      drive(v);
      for (int c = 0; c < 24; c++) begin
         if (instr_valid && instr[15:12] == DPY) got.push_back(int'(instr[11:4]));
         @(posedge clk); #1;
      end
      n_exp = (D < 5) ? D : 5;
      chk("drain.count", 0, 16'(got.size()), 16'(n_exp));
      for (int k = 0; k < got.size() && k < n_exp; k++)
         chk("drain.amt", k, 16'(got[k]), 16'(k + 1));
      chk("drain.drop", 0, 16'(drop_cnt), 16'((5 > D) ? 5 - D : 0));

      // Zero-amount damage ignored; pop and push in the same cycle on a full queue.
      tbl.push_back(mk(1,0,0,0,0,0,0,0, 0,16'h0000,0,0));
      tbl.push_back(mk(0,0,0,1,0,0,0,0, 0,16'h0000,0,0));
      tbl.push_back(mk(0,0,0,0,0,0,0,0, 0,16'h0000,0,0));
      for (int k = 0; k < D; k++)
         tbl.push_back(mk(0,0,0,1,8'(11 + k),0,0,0, (k >= 1), (k >= 1) ? 16'h20B0 : 16'h0000,
                          (k + 1 >= D), 0));
      tbl.push_back(mk(0,0,0,0,0,0,0,0, 1,16'h20B0,1,0));
      tbl.push_back(mk(0,0,0,1,99,0,0,1, 0,16'h20B0,1,0));
      tbl.push_back(mk(0,0,0,0,0,0,0,1, 1,(D == 1) ? 16'h2630 : 16'h20C0,1,0));
      run_tbl("pushpop");

      // Randomized run against the reference model.
      v = mk(0,0,0,0,0,0,0,0, 0,0,0,0);
      for (int c = 0; c < 800; c++) begin
         v.rst  = (c == 0) || ($urandom_range(0, 63) == 0);
         if ($urandom_range(0, 3) == 0) v.mov = ~v.mov;
         v.dir  = 8'($urandom_range(0, 3));
         v.dmg  = ($urandom_range(0, 2) == 0);
         v.damt = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
         v.heal = ($urandom_range(0, 7) == 0);
         v.hamt = 8'($urandom_range(0, 255));
         v.rdy  = ($urandom_range(0, 4) != 0);
         drive(v);
         model_step(v);
         @(posedge clk); #1;
         chk("rnd.valid", c, 16'(instr_valid), 16'(m_valid));
         chk("rnd.instr", c, instr, m_instr);
         chk("rnd.q_full", c, 16'(q_full), 16'(mq.size() == D));
         chk("rnd.drop", c, 16'(drop_cnt), 16'(m_drop));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
